// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR link checker:
// word width, checker state encoding and the LFSR next-word function.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // One step of the fixed polynomial: shift left, feedback taps 15/13/12/10.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

endpackage : lfsr_pkg

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word (result 0..16).
module popcount16
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] data,
    output logic [4:0]        count
);

    // Sum the individual bits of the word.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < LFSR_W; i++) begin
            count = count + 5'(data[i]);
        end
    end

endmodule : popcount16

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a 16-bit Fibonacci LFSR word stream.
// HUNT seeds from the first non-zero word, SYNC confirms LOCK_COUNT
// consecutive predictions, LOCKED flywheels the prediction and counts
// word and bit errors until LOSS_COUNT consecutive misses drop the lock.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              clear_errs,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  bit_err_count
);

    // Match/miss counters share one width large enough for either threshold.
    localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Bit-error sum needs room for the counter plus a full-word popcount and a carry.
    localparam int SUM_W   = ((ERR_W > 5) ? ERR_W : 5) + 1;

    chk_state_t         state_r, state_nxt_s;
    logic [LFSR_W-1:0]  expected_r, expected_nxt_s;
    logic [CNT_W-1:0]   match_cnt_r, match_cnt_nxt_s;
    logic [CNT_W-1:0]   miss_cnt_r, miss_cnt_nxt_s;
    logic               locked_r, locked_nxt_s;
    logic               err_pulse_r, err_pulse_nxt_s;
    logic [ERR_W-1:0]   err_count_r, err_count_nxt_s;
    logic [ERR_W-1:0]   bit_err_count_r, bit_err_count_nxt_s;

    logic [LFSR_W-1:0]  diff_s;
    logic [4:0]         diff_pop_s;
    logic [SUM_W-1:0]   bit_sum_s;
    logic [ERR_W-1:0]   bit_sat_s;
    logic [ERR_W-1:0]   err_inc_s;
    logic               word_match_s;
    logic               word_zero_s;

    assign diff_s       = in_data ^ expected_r;
    assign word_match_s = (diff_s == 16'h0000);
    assign word_zero_s  = (in_data == 16'h0000);

    popcount16 u_popcount (
        .data  (diff_s),
        .count (diff_pop_s)
    );

    // Saturating increments for the word-error and bit-error counters.
    always_comb begin
        bit_sum_s = SUM_W'(bit_err_count_r) + SUM_W'(diff_pop_s);
        if (bit_sum_s > SUM_W'({ERR_W{1'b1}})) begin
            bit_sat_s = {ERR_W{1'b1}};
        end else begin
            bit_sat_s = bit_sum_s[ERR_W-1:0];
        end
        if (err_count_r == {ERR_W{1'b1}}) begin
            err_inc_s = err_count_r;
        end else begin
            err_inc_s = err_count_r + ERR_W'(1);
        end
    end

    // Next-state, prediction and error bookkeeping for one received beat.
    always_comb begin
        state_nxt_s         = state_r;
        expected_nxt_s      = expected_r;
        match_cnt_nxt_s     = match_cnt_r;
        miss_cnt_nxt_s      = miss_cnt_r;
        locked_nxt_s        = locked_r;
        err_pulse_nxt_s     = 1'b0;
        err_count_nxt_s     = err_count_r;
        bit_err_count_nxt_s = bit_err_count_r;

        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    // All-zero is the LFSR lock-up word and never a usable seed.
                    if (!word_zero_s) begin
                        expected_nxt_s  = lfsr_next(in_data);
                        match_cnt_nxt_s = '0;
                        state_nxt_s     = SYNC;
                    end else begin
                        state_nxt_s     = HUNT;
                    end
                end
                SYNC: begin
                    if (word_zero_s) begin
                        state_nxt_s     = HUNT;
                        match_cnt_nxt_s = '0;
                    end else if (word_match_s) begin
                        expected_nxt_s = lfsr_next(in_data);
                        if (match_cnt_r == CNT_W'(LOCK_COUNT - 1)) begin
                            state_nxt_s     = LOCKED;
                            locked_nxt_s    = 1'b1;
                            miss_cnt_nxt_s  = '0;
                            match_cnt_nxt_s = '0;
                        end else begin
                            match_cnt_nxt_s = match_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        // Reseed from the received word and restart confirmation.
                        expected_nxt_s  = lfsr_next(in_data);
                        match_cnt_nxt_s = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances from itself, never from the data.
                    expected_nxt_s = lfsr_next(expected_r);
                    if (word_match_s) begin
                        miss_cnt_nxt_s = '0;
                    end else begin
                        err_pulse_nxt_s     = 1'b1;
                        err_count_nxt_s     = err_inc_s;
                        bit_err_count_nxt_s = bit_sat_s;
                        if (miss_cnt_r == CNT_W'(LOSS_COUNT - 1)) begin
                            state_nxt_s    = HUNT;
                            locked_nxt_s   = 1'b0;
                            miss_cnt_nxt_s = '0;
                        end else begin
                            miss_cnt_nxt_s = miss_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s     = HUNT;
                    locked_nxt_s    = 1'b0;
                    match_cnt_nxt_s = '0;
                    miss_cnt_nxt_s  = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        // Clearing wins over a same-cycle increment; the pulse is unaffected.
        if (clear_errs) begin
            err_count_nxt_s     = '0;
            bit_err_count_nxt_s = '0;
        end else begin
            err_count_nxt_s     = err_count_nxt_s;
            bit_err_count_nxt_s = bit_err_count_nxt_s;
        end
    end

    // State, prediction and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= HUNT;
            expected_r      <= 16'h0000;
            match_cnt_r     <= '0;
            miss_cnt_r      <= '0;
            locked_r        <= 1'b0;
            err_pulse_r     <= 1'b0;
            err_count_r     <= '0;
            bit_err_count_r <= '0;
        end else begin
            state_r         <= state_nxt_s;
            expected_r      <= expected_nxt_s;
            match_cnt_r     <= match_cnt_nxt_s;
            miss_cnt_r      <= miss_cnt_nxt_s;
            locked_r        <= locked_nxt_s;
            err_pulse_r     <= err_pulse_nxt_s;
            err_count_r     <= err_count_nxt_s;
            bit_err_count_r <= bit_err_count_nxt_s;
        end
    end

    assign locked        = locked_r;
    assign err_pulse     = err_pulse_r;
    assign err_count     = err_count_r;
    assign bit_err_count = bit_err_count_r;

endmodule : lfsr_checker

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed scenarios followed by a
// randomized LFSR stream with corruption, gaps, zeros, clears and resets.
module tb_lfsr_checker;

    localparam int EW  = 6;
    localparam int LC  = 4;
    localparam int LS  = 3;
    localparam int MAXC = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = 16'h0000;
    logic          clear_errs = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic [EW-1:0] bit_err_count;

    lfsr_checker #(.LOCK_COUNT(LC), .LOSS_COUNT(LS), .ERR_W(EW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .clear_errs    (clear_errs),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_err_count (bit_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit lk;
        bit ep;
        int ec;
        int bc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked.
    int m_mode = 0, m_exp = 0, m_match = 0, m_miss = 0;
    bit m_lk = 0, m_ep = 0;
    int m_ec = 0, m_bc = 0;
    int g = 1;

    function automatic int nx(input int x);
        int fb;
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return ((x * 2) % 65536) + fb;
    endfunction

    function automatic int pc(input int x);
        int n = 0;
        for (int i = 0; i < 16; i++) n += (x >> i) & 1;
        return n;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic model(input bit rst, input bit v, input int d, input bit clr);
        int e;
        if (rst) begin
            m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
            m_lk = 0; m_ep = 0; m_ec = 0; m_bc = 0;
            return;
        end
        m_ep = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin m_exp = nx(d); m_match = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == 0) m_mode = 0;
                else if (d == m_exp) begin
                    m_exp = nx(d); m_match++;
                    if (m_match == LC) begin m_mode = 2; m_lk = 1; m_miss = 0; end
                end else begin
                    m_exp = nx(d); m_match = 0;
                end
            end else begin
                e = m_exp;
                m_exp = nx(m_exp);
                if (d == e) m_miss = 0;
                else begin
                    m_ep = 1;
                    m_ec = sat(m_ec + 1);
                    m_bc = sat(m_bc + pc(d ^ e));
                    m_miss++;
                    if (m_miss == LS) begin m_mode = 0; m_lk = 0; end
                end
            end
        end
        if (clr) begin m_ec = 0; m_bc = 0; end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and enqueue the outputs expected after the next edge.
    task automatic beat(input bit rst, input bit v, input logic [15:0] d, input bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; in_valid = v; in_data = d; clear_errs = clr;
        model(rst, v, int'(d), clr);
        e.tag = cyc + 1; e.lk = m_lk; e.ep = m_ep; e.ec = m_ec; e.bc = m_bc;
        q.push_back(e);
    endtask

    // Send the next generator word, optionally corrupted by mask.
    task automatic sendg(input int mask, input bit clr);
        logic [15:0] w;
        w = 16'(g ^ mask);
        g = nx(g);
        beat(1'b0, 1'b1, w, clr);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tot++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Monitor: compare every expectation whose capturing edge has passed.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            chk("locked", int'(locked), int'(e.lk));
            chk("err_pulse", int'(err_pulse), int'(e.ep));
            chk("err_count", int'(err_count), e.ec);
            chk("bit_err_count", int'(bit_err_count), e.bc);
        end
    end

    initial begin
        int r;
        // Reset
        beat(1'b1, 1'b0, 16'h0000, 1'b0);
        beat(1'b1, 1'b0, 16'h0000, 1'b0);
        // Walking-one stream locks after five beats, then again with gaps
        g = 1;
        for (int i = 0; i < 6; i++) sendg(0, 1'b0);
        beat(1'b1, 1'b0, 16'h0000, 1'b0);
        g = 1;
        for (int i = 0; i < 6; i++) begin
            beat(1'b0, 1'b0, 16'($urandom), 1'b0);
            sendg(0, 1'b0);
        end
        // Lock on 0xACE1, two-bit error, then good word
        beat(1'b1, 1'b0, 16'h0000, 1'b0);
        g = 16'hACE1;
        for (int i = 0; i < 5; i++) sendg(0, 1'b0);
        sendg(3, 1'b0);
        sendg(0, 1'b0);
        beat(1'b0, 1'b0, 16'h0000, 1'b0);
        // Three consecutive errors drop lock; good stream relocks
        for (int i = 0; i < 3; i++) sendg(16'h0100 << i, 1'b0);
        for (int i = 0; i < 7; i++) sendg(0, 1'b0);
        // All-zero stream, then SYNC interrupted by zero
        beat(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) beat(1'b0, 1'b1, 16'h0000, 1'b0);
        g = 16'h1234;
        sendg(0, 1'b0); sendg(0, 1'b0);
        beat(1'b0, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) sendg(0, 1'b0);
        // Saturation with single-bit errors interleaved with good words
        for (int i = 0; i < 70; i++) begin
            sendg(1 << (i % 16), 1'b0);
            sendg(0, 1'b0);
        end
        // Clear coincident with an error
        sendg(16'h00F0, 1'b1);
        sendg(0, 1'b0);
        sendg(16'h8001, 1'b0);
        sendg(0, 1'b0);
        // Reset while locked with nonzero counters; next word seeds
        beat(1'b1, 1'b1, 16'h5555, 1'b0);
        for (int i = 0; i < 6; i++) sendg(0, 1'b0);
        // Randomized stream
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                beat(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            end else if ($urandom_range(0, 3) == 0) begin
                beat(1'b0, 1'b0, 16'($urandom), 1'($urandom_range(0, 29) == 0));
            end else if ($urandom_range(0, 39) == 0) begin
                beat(1'b0, 1'b1, 16'h0000, 1'b0);
            end else begin
                if ($urandom_range(0, 59) == 0) g = $urandom_range(1, 65535);
                r = $urandom_range(0, 9);
                if (r == 0) sendg($urandom_range(1, 65535), 1'($urandom_range(0, 29) == 0));
                else if (r == 1) sendg(1 << $urandom_range(0, 15), 1'b0);
                else sendg(0, 1'($urandom_range(0, 29) == 0));
            end
        end
        beat(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (5) @(posedge clk);
        if (q.size() != 0) begin
            n_tot++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_lfsr_checker
